// File: rtl/obi_mem_responder.sv
// OBI memory responder: word RAM behind a fixed-latency response pipeline.
// Ports: clk_i/rst_i (sync, active-high); req_i/gnt_o/we_i/be_i/addr_i/wdata_i
//   request channel; rvalid_o/rdata_o response channel; stall_i forces gnt_o low.
module obi_mem_responder #(
  parameter int MEM_DEPTH       = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  stall_i
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  logic [AW-1:0]         idx;
  logic                  accept;
  logic [CW-1:0]         cnt_q;
  logic [LATENCY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  assign idx = addr_i[AW+1:2];

  generate
    if (ADDR_WIDTH > AW + 2) begin : g_hi
      logic unused_addr;
      assign unused_addr = ^{addr_i[ADDR_WIDTH-1:AW+2], addr_i[1:0]};
    end else begin : g_lo
      logic unused_addr;
      assign unused_addr = ^addr_i[1:0];
    end
  endgenerate

  // A response leaving this cycle frees a slot, so a full
  // counter can still take a new request in the same cycle.
  assign gnt_o = req_i && !stall_i && !rst_i &&
                 ((cnt_q < MAX_CNT) || rvalid_o);
  assign accept = req_i && gnt_o;

  assign rvalid_o = valid_q[LATENCY-1];
  assign rdata_o  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;

  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      unique case ({accept, rvalid_o})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Read data is captured at acceptance; writes respond with zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= accept;
      data_q[0]  <= (accept && !we_i) ? mem[idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: random traffic against a queue model,
// plus directed literal checks on a second, deeper-latency instance.
module tb_obi_mem_responder;

  localparam int L = 2;
  localparam int M = 2;
  localparam int DEPTH = 1024;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic        req = 0, we = 0, stall = 0;
  logic [3:0]  be = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        b_req = 0, b_we = 0, b_stall = 0;
  logic [3:0]  b_be = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;

  obi_mem_responder #(
    .MEM_DEPTH(DEPTH), .LATENCY(L), .MAX_OUTSTANDING(M),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .rvalid_o(rvalid), .stall_i(stall)
  );

  obi_mem_responder #(
    .MEM_DEPTH(16), .LATENCY(4), .MAX_OUTSTANDING(2),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt),
    .we_i(b_we), .be_i(b_be), .addr_i(b_addr), .wdata_i(b_wdata),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid), .stall_i(b_stall)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed word memory and a FIFO of
  // pending responses, each stamped with the cycle it is due.
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mmem [DEPTH] = '{default: '0};
  resp_t       q [$];
  int          cyc = 0;
  logic        chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_rv, e_gnt;
      logic [31:0] e_rd;
      int          w;
      resp_t       r;
      e_rv  = (q.size() > 0) && (q[0].due == cyc);
      e_gnt = req && !stall && !rst && ((q.size() < M) || e_rv);
      e_rd  = e_rv ? q[0].data : 32'h0;
      cmp("gnt", {31'b0, gnt}, {31'b0, e_gnt});
      cmp("rvalid", {31'b0, rvalid}, {31'b0, e_rv});
      cmp("rdata", rdata, e_rd);
      if (e_rv) void'(q.pop_front());
      if (rst) begin
        q.delete();
      end else if (e_gnt) begin
        w = int'((addr / 4) % DEPTH);
        r.due = cyc + L;
        r.data = we ? 32'h0 : mmem[w];
        q.push_back(r);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mmem[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      cyc++;
    end
  end

  task automatic op(input logic w, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rd, output int lat);
    logic done;
    rd = 32'hffff_ffff;
    lat = -1;
    @(posedge clk); #1;
    req = 1; we = w; be = b; addr = a; wdata = d;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (gnt) done = 1;
    end
    @(posedge clk); #1;
    req = 0;
    if (!done) begin
      cmp("op_grant_timeout", 32'h0, 32'h1);
    end else begin
      done = 0;
      for (int i = 1; i <= 20 && !done; i++) begin
        @(negedge clk);
        if (rvalid) begin
          lat = i; rd = rdata; done = 1;
        end
      end
      if (!done) cmp("op_resp_timeout", 32'h0, 32'h1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic [9:0]  gm, rm;
    int          gc, rvc;
    logic [31:0] a;

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;

    // Outstanding limit with LATENCY=4, MAX_OUTSTANDING=2
    @(posedge clk); #1;
    b_req = 1; b_we = 0; b_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gm[i] = b_gnt;
      rm[i] = b_rvalid;
      if (b_rvalid) cmp("b_rdata", b_rdata, 32'h0);
    end
    @(posedge clk); #1;
    b_req = 0;
    cmp("b_gnt_pattern", {22'b0, gm}, 32'h333);
    cmp("b_rvalid_pattern", {22'b0, rm}, 32'h330);
    repeat (8) @(posedge clk);

    // Write/read-back
    op(1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
    cmp("wr_latency", lat, 2);
    cmp("wr_rdata", rd, 32'h0);
    op(0, 4'hF, 32'h10, 32'h0, rd, lat);
    cmp("rd_latency", lat, 2);
    cmp("rd_data", rd, 32'hDEADBEEF);

    // Byte enables
    op(1, 4'b0101, 32'h10, 32'h11223344, rd, lat);
    op(0, 4'hF, 32'h10, 32'h0, rd, lat);
    cmp("be_merge", rd, 32'hDE22BE44);
    op(1, 4'h0, 32'h10, 32'hFFFFFFFF, rd, lat);
    cmp("be0_resp_latency", lat, 2);
    op(0, 4'hF, 32'h13, 32'h0, rd, lat);
    cmp("be0_unchanged", rd, 32'hDE22BE44);

    // Aliasing
    op(1, 4'hF, 32'h1010, 32'hCAFEF00D, rd, lat);
    op(0, 4'hF, 32'h0010, 32'h0, rd, lat);
    cmp("alias", rd, 32'hCAFEF00D);

    // Stall
    @(posedge clk); #1;
    req = 1; stall = 1; we = 0; addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("stall_gnt", {31'b0, gnt}, 32'h0);
      cmp("stall_rvalid", {31'b0, rvalid}, 32'h0);
    end
    @(posedge clk); #1;
    req = 0; stall = 0;
    repeat (4) @(posedge clk);

    // Back-to-back burst: accept and rvalid coincide
    #1;
    req = 1; we = 0; addr = 32'h10;
    gc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt) gc++;
      @(posedge clk); #1;
    end
    req = 0;
    cmp("burst_grants", gc, 6);
    repeat (4) @(posedge clk);

    // Reset with a write and a read in flight
    #1;
    req = 1; we = 1; be = 4'hF; addr = 32'h40; wdata = 32'h12345678;
    @(negedge clk);
    cmp("rst_wr_gnt", {31'b0, gnt}, 32'h1);
    @(posedge clk); #1;
    we = 0;
    @(negedge clk);
    cmp("rst_rd_gnt", {31'b0, gnt}, 32'h1);
    @(posedge clk); #1;
    req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    rvc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid) rvc++;
    end
    cmp("rst_no_late_rvalid", rvc, 0);
    op(0, 4'hF, 32'h40, 32'h0, rd, lat);
    cmp("rst_mem_kept", rd, 32'h12345678);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      req   = ($urandom_range(0, 99) < 70);
      we    = $urandom_range(0, 1) == 1;
      be    = 4'($urandom);
      addr  = a;
      wdata = $urandom;
      stall = ($urandom_range(0, 99) < 15);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    req = 0; stall = 0; rst = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
